// File: rtl/dbuf_write_sched_if.sv
// Bus bundle for the display-buffer write scheduler: pixel push port,
// clear-engine control and the memory write port.
// master = requester/memory side, slave = the scheduler itself.
interface dbuf_write_sched_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              pix_we;
    logic [ADDR_W-1:0] pix_addr;
    logic [DATA_W-1:0] pix_data;
    logic              pix_full;
    logic              pix_ovf;

    logic              clr_req;
    logic [DATA_W-1:0] clr_color;
    logic              clr_busy;
    logic              clr_done;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;

    modport master (
        output pix_we, pix_addr, pix_data, clr_req, clr_color, mem_ready,
        input  pix_full, pix_ovf, clr_busy, clr_done, mem_we, mem_addr, mem_data
    );

    modport slave (
        input  pix_we, pix_addr, pix_data, clr_req, clr_color, mem_ready,
        output pix_full, pix_ovf, clr_busy, clr_done, mem_we, mem_addr, mem_data
    );
endinterface

// File: rtl/dbuf_write_sched.sv
// Display-buffer write scheduler: arbitrates the single memory write port
// between a buffered pixel stream (priority) and a frame-clear engine.
// Build option: define DBUF_CLEAR_EN to compile in the clear engine and its
// starvation guard; without it the block is just pixel FIFO + output register.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no clear running; only pixel writes are issued
// CLEAR  | filling the buffer; pixels win unless STARVE_MAX in a row granted
module dbuf_write_sched #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int SCREEN_WORDS = 61440,
    parameter int STARVE_MAX   = 8
) (
    input logic               Fphi0,
    input logic               rst,
    dbuf_write_sched_if.slave bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_ovf;
    logic              r_mem_we;
    logic              r_mem_is_clr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_data;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_slot_free;
    logic              w_grant_clr;
    logic [ADDR_W-1:0] w_clr_addr;
    logic [DATA_W-1:0] w_clr_color;

    // Full is a compare on the registered count, so a simultaneous pop
    // never makes room for a push in the same cycle.
    assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_push      = bus.pix_we && !w_full;
    assign w_slot_free = !r_mem_we || bus.mem_ready;

`ifdef DBUF_CLEAR_EN
    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    localparam int STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCREEN_WORDS - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_clr_addr;
    logic [ADDR_W-1:0] w_clr_addr_nxt;
    logic [DATA_W-1:0] r_clr_color;
    logic [DATA_W-1:0] w_clr_color_nxt;
    logic [STV_W-1:0]  r_starve;
    logic [STV_W-1:0]  w_starve_nxt;
    logic              r_clr_done;
    logic              w_clr_done_nxt;
    logic              w_clr_acc;
    logic              w_last_acc;

    // r_clr_addr counts accepted clear words; the word to issue next has to
    // look past a clear word being accepted at this very edge.
    assign w_clr_acc   = r_mem_we && r_mem_is_clr && bus.mem_ready;
    assign w_last_acc  = w_clr_acc && (r_mem_addr == LAST_ADDR);
    assign w_clr_addr  = w_clr_acc ? (r_clr_addr + 1'b1) : r_clr_addr;
    assign w_clr_color = r_clr_color;

    assign w_pop       = w_slot_free && !w_empty &&
                         ((r_state == S_IDLE) || (r_starve < STV_W'(STARVE_MAX)));
    assign w_grant_clr = w_slot_free && (r_state == S_CLEAR) && !w_pop && !w_last_acc;

    // Clear FSM state and its counters.
    always_ff @(posedge Fphi0 or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_clr_addr  <= '0;
            r_clr_color <= '0;
            r_starve    <= '0;
            r_clr_done  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_clr_addr  <= w_clr_addr_nxt;
            r_clr_color <= w_clr_color_nxt;
            r_starve    <= w_starve_nxt;
            r_clr_done  <= w_clr_done_nxt;
        end
    end

    // Next-state, clear address advance and starvation bookkeeping.
    always_comb begin
        w_state_nxt     = r_state;
        w_clr_addr_nxt  = r_clr_addr;
        w_clr_color_nxt = r_clr_color;
        w_starve_nxt    = r_starve;
        w_clr_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.clr_req) begin
                    w_state_nxt     = S_CLEAR;
                    w_clr_addr_nxt  = '0;
                    w_clr_color_nxt = bus.clr_color;
                end
            end
            S_CLEAR: begin
                if (w_clr_acc && !w_last_acc) begin
                    w_clr_addr_nxt = r_clr_addr + 1'b1;
                end
                if (w_pop) begin
                    if (r_starve != STV_W'(STARVE_MAX)) begin
                        w_starve_nxt = r_starve + 1'b1;
                    end
                end else if (w_grant_clr) begin
                    w_starve_nxt = '0;
                end
                if (w_last_acc) begin
                    w_state_nxt    = S_IDLE;
                    w_clr_done_nxt = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.clr_busy = (r_state == S_CLEAR);
    assign bus.clr_done = r_clr_done;
`else
    logic w_unused_clr;

    assign w_pop        = w_slot_free && !w_empty;
    assign w_grant_clr  = 1'b0;
    assign w_clr_addr   = '0;
    assign w_clr_color  = '0;
    assign bus.clr_busy = 1'b0;
    assign bus.clr_done = 1'b0;
    assign w_unused_clr = ^{bus.clr_req, bus.clr_color, r_mem_is_clr,
                            SCREEN_WORDS[0], STARVE_MAX[0]};
`endif

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge Fphi0) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= bus.pix_addr;
            r_fifo_data[r_wr_ptr] <= bus.pix_data;
        end
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge Fphi0 or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Output slot: load a granted word when free, otherwise hold it stable.
    always_ff @(posedge Fphi0 or posedge rst) begin
        if (rst) begin
            r_mem_we     <= 1'b0;
            r_mem_is_clr <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_data   <= '0;
            r_ovf        <= 1'b0;
        end else begin
            if (bus.pix_we && w_full) r_ovf <= 1'b1;
            if (w_slot_free) begin
                if (w_pop) begin
                    r_mem_we     <= 1'b1;
                    r_mem_is_clr <= 1'b0;
                    r_mem_addr   <= r_fifo_addr[r_rd_ptr];
                    r_mem_data   <= r_fifo_data[r_rd_ptr];
                end else if (w_grant_clr) begin
                    r_mem_we     <= 1'b1;
                    r_mem_is_clr <= 1'b1;
                    r_mem_addr   <= w_clr_addr;
                    r_mem_data   <= w_clr_color;
                end else begin
                    r_mem_we     <= 1'b0;
                    r_mem_is_clr <= 1'b0;
                end
            end
        end
    end

    assign bus.pix_full = w_full;
    assign bus.pix_ovf  = r_ovf;
    assign bus.mem_we   = r_mem_we;
    assign bus.mem_addr = r_mem_addr;
    assign bus.mem_data = r_mem_data;
endmodule

// File: tb/tb_dbuf_write_sched.sv
// Bench for dbuf_write_sched: directed scenarios plus random traffic, all
// compared each cycle against a queue-based behavioural model.
module tb_dbuf_write_sched;
    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int SW    = 16;
    localparam int SM    = 2;
`ifdef DBUF_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } word_t;

    logic Fphi0;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   n_done_seen;
    int   n_we_seen;

    dbuf_write_sched_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dbuf_write_sched #(
        .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH),
        .SCREEN_WORDS(SW), .STARVE_MAX(SM)
    ) dut (
        .Fphi0(Fphi0),
        .rst  (rst),
        .bus  (bus)
    );

    initial begin
        Fphi0 = 1'b0;
        forever #5 Fphi0 = ~Fphi0;
    end

    // reference model state
    word_t         m_q[$];
    bit            m_valid, m_is_clr, m_clearing, m_ovf, m_done;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data, m_color;
    int            m_issued, m_starve;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_valid = 0; m_is_clr = 0; m_clearing = 0; m_ovf = 0; m_done = 0;
        m_addr = '0; m_data = '0; m_color = '0; m_issued = 0; m_starve = 0;
    endtask

    // One clock edge of the scheduler's rules, applied to pre-edge inputs.
    task automatic model_step(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input bit creq, input logic [DW-1:0] cc, input bit rdy);
        bit    acc, free, last, full, was_clr;
        word_t w;
        acc     = m_valid && rdy;
        free    = !m_valid || rdy;
        last    = acc && m_is_clr && (m_addr == AW'(SW - 1));
        full    = (m_q.size() == DEPTH);
        was_clr = m_clearing;
        if (free) begin
            if (m_q.size() != 0 && (!was_clr || m_starve < SM)) begin
                w = m_q.pop_front();
                m_valid = 1; m_is_clr = 0; m_addr = w.a; m_data = w.d;
                if (was_clr) m_starve = (m_starve < SM) ? m_starve + 1 : SM;
            end else if (was_clr && !last && m_issued < SW) begin
                m_valid = 1; m_is_clr = 1; m_addr = AW'(m_issued); m_data = m_color;
                m_issued++;
                m_starve = 0;
            end else begin
                m_valid = 0; m_is_clr = 0;
            end
        end
        if (we) begin
            if (full) m_ovf = 1;
            else m_q.push_back(word_t'{a: a, d: d});
        end
        m_done = last;
        if (last) m_clearing = 0;
        else if (!was_clr && creq && CLEAR_EN) begin
            m_clearing = 1; m_color = cc; m_issued = 0;
        end
    endtask

    task automatic check_outputs();
        chk("mem_we", bus.mem_we, m_valid);
        if (m_valid) begin
            chk("mem_addr", bus.mem_addr, m_addr);
            chk("mem_data", bus.mem_data, m_data);
        end
        chk("pix_full", bus.pix_full, m_q.size() == DEPTH);
        chk("pix_ovf", bus.pix_ovf, m_ovf);
        chk("clr_busy", bus.clr_busy, m_clearing);
        chk("clr_done", bus.clr_done, m_done);
    endtask

    task automatic cycle(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input bit creq, input logic [DW-1:0] cc, input bit rdy);
        bus.pix_we    = we;
        bus.pix_addr  = a;
        bus.pix_data  = d;
        bus.clr_req   = creq;
        bus.clr_color = cc;
        bus.mem_ready = rdy;
        @(posedge Fphi0);
        model_step(we, a, d, creq, cc, rdy);
        #1;
        check_outputs();
        if (bus.clr_done) n_done_seen++;
        if (bus.mem_we) n_we_seen++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge Fphi0);
        #1;
        rst = 1'b0;
        model_reset();
        check_outputs();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(0, '0, '0, 0, '0, rdy);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0; n_fail = 0; n_done_seen = 0; n_we_seen = 0;
        bus.pix_we = 0; bus.pix_addr = '0; bus.pix_data = '0;
        bus.clr_req = 0; bus.clr_color = '0; bus.mem_ready = 0;
        model_reset();
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_full", bus.pix_full, 0);
        chk("rst_ovf", bus.pix_ovf, 0);
        chk("rst_busy", bus.clr_busy, 0);
        chk("rst_done", bus.clr_done, 0);
        @(posedge Fphi0);
        #1 rst = 1'b0;
        check_outputs();

        // single pixel
        cycle(1, 16'h0010, 32'h00FF8040, 0, '0, 1);
        cycle(0, '0, '0, 0, '0, 1);
        chk("px_we", bus.mem_we, 1);
        chk("px_addr", bus.mem_addr, 16'h0010);
        chk("px_data", bus.mem_data, 32'h00FF8040);
        cycle(0, '0, '0, 0, '0, 1);
        chk("px_we_off", bus.mem_we, 0);

        // backpressure and overflow
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(1, AW'(16'h0100 + i), DW'(32'hA000 + i), 0, '0, 0);
            if (i == 4) chk("bp_full5", bus.pix_full, 1);
        end
        chk("bp_ovf", bus.pix_ovf, 1);
        chk("bp_hold", bus.mem_addr, 16'h0100);
        idle(8, 1);

        // clear alone
        do_reset();
        n_done_seen = 0; n_we_seen = 0;
        cycle(0, '0, '0, 1, 32'h00202020, 1);
        idle(22, 1);
        chk("clr_words", n_we_seen, CLEAR_EN ? SW : 0);
        chk("clr_done_cnt", n_done_seen, CLEAR_EN ? 1 : 0);
        chk("clr_busy_end", bus.clr_busy, 0);

        // starvation guard: continuous pixels during a clear
        do_reset();
        n_done_seen = 0;
        cycle(1, 16'h4000, 32'h11, 1, 32'h00ABCDEF, 1);
        for (int i = 0; i < 70; i++) cycle(1, AW'(16'h4001 + i), DW'($urandom), 0, '0, 1);
        idle(10, 1);
        chk("starve_done", n_done_seen, CLEAR_EN ? 1 : 0);

        // reset mid-clear after 5 accepted clear words
        do_reset();
        n_done_seen = 0;
        cycle(0, '0, '0, 1, 32'h00555555, 1);
        idle(6, 1);
        #2 rst = 1'b1;
        #1;
        chk("abort_we", bus.mem_we, 0);
        chk("abort_busy", bus.clr_busy, 0);
        chk("abort_done", bus.clr_done, 0);
        chk("abort_addr", bus.mem_addr, 0);
        model_reset();
        @(posedge Fphi0);
        #1 rst = 1'b0;
        check_outputs();
        chk("abort_no_done", n_done_seen, 0);
        cycle(0, '0, '0, 1, 32'h00777777, 1);
        idle(22, 1);

        // random traffic
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 9) < 6, AW'($urandom), DW'($urandom),
                  $urandom_range(0, 49) == 0, DW'($urandom), $urandom_range(0, 9) < 7);
        end
        idle(60, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dbuf_write_sched.md
# dbuf_write_sched

Write scheduler for the display buffer port. It shares the single display-buffer write port between two requesters: the GTIA pixel stream and a frame-clear engine that fills the buffer with a background colour. It sits between GTIA's `dBuf_*` outputs and the display-buffer memory. Pixel writes are buffered in a small FIFO and have priority over clear writes. A starvation guard guarantees that a pending clear still makes progress.

## Interface
Parameters:
- `ADDR_W`, 16: display-buffer address width.
- `DATA_W`, 32: display-buffer data width.
- `FIFO_DEPTH`, 4: pixel FIFO entries; must be a power of two and ≥2.
- `SCREEN_WORDS`, 61440: words written by one clear (320×192).
- `STARVE_MAX`, 8: maximum number of consecutive pixel grants while a clear is pending.

Ports:
- `Fphi0`  in  1  clock. One clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `pix_we`  in  1  pixel write request; same meaning as GTIA `dBuf_writeEn`.
- `pix_addr`  in  ADDR_W  pixel address.
- `pix_data`  in  DATA_W  pixel data; `{8'd0, RGB}` from GTIA.
- `pix_full`  out  1  FIFO full; a `pix_we` in this cycle is dropped.
- `pix_ovf`  out  1  sticky flag: a pixel write was dropped.
- `clr_req`  in  1  start-clear request, sampled per cycle.
- `clr_color`  in  DATA_W  fill value, latched when a clear starts.
- `clr_busy`  out  1  clear in progress.
- `clr_done`  out  1  one-cycle pulse when a clear completes.
- `mem_we`  out  1  memory write valid.
- `mem_addr`  out  ADDR_W  memory write address.
- `mem_data`  out  DATA_W  memory write data.
- `mem_ready`  in  1  memory accepts the write at this edge when `mem_we` is high.

## Operation
- **Reset values:** all outputs 0. FIFO empty, state IDLE, clear address counter 0, starve counter 0.
- **Pixel FIFO:**
  - Push at an edge when `pix_we && !pix_full`.
  - `pix_full = (count == FIFO_DEPTH)`. It is a registered-count compare, so a push is refused when the FIFO is full even if a pop happens at the same edge.
  - `pix_we && pix_full` drops the write and sets `pix_ovf`. Only `rst` clears `pix_ovf`.
- **Output slot:**
  - The output registers (`mem_we`/`mem_addr`/`mem_data`) are free when `!mem_we || mem_ready`.
  - While `mem_we && !mem_ready`, the address and data are held stable.
- **Clear FSM:**
  - States: IDLE, CLEAR.
  - IDLE→CLEAR on `clr_req`. This latches `clr_color`, sets the address counter to 0, and sets `clr_busy`.
  - `clr_req` is ignored while in CLEAR.
- **Grant rule** (evaluated when the slot is free):
  - If the FIFO is non-empty and (state is IDLE or `starve < STARVE_MAX`): pop the FIFO into the output registers. In CLEAR, `starve` increments.
  - Otherwise, if in CLEAR: issue `{clr_addr, clr_color}` and reset `starve` to 0.
  - Otherwise: `mem_we` = 0.
- **Clear address:** increments by 1 when a clear write is accepted (`mem_we && mem_ready` on a clear word).
- **Clear completion:**
  - Acceptance of word `SCREEN_WORDS-1` returns the FSM to IDLE.
  - At that same edge, `clr_busy` falls and `clr_done` pulses for one cycle.
  - No further clear words are issued after the last one.
- **Arithmetic:** the address counter is ADDR_W wide with no wrap past `SCREEN_WORDS-1`. The starve counter saturates at `STARVE_MAX`.
- **Reset mid-operation:**
  - `rst` aborts any clear, empties the FIFO, and drops `mem_we` immediately.
  - No `clr_done` is generated for an aborted clear.

## Timing
- **Pixel latency:** a pixel pushed at edge N with an empty FIFO and a free slot drives `mem_we` after edge N+1. Sustained throughput is 1 word/cycle with `mem_ready` high.
- **Clear start:** `clr_req` sampled at edge N makes `clr_busy` high after N. The first clear word appears after N+1 if the FIFO is empty.
- **Clear duration:** with `mem_ready` held high and no pixel traffic, a clear takes exactly `SCREEN_WORDS` accept cycles.
- **Contention:** with continuous pixel traffic during CLEAR, at least 1 clear word is granted per `STARVE_MAX+1` slots.
- **Simultaneous events:**
  - `clr_req` at the same edge as the final clear accept is ignored.
  - A push and a pop at the same edge with a non-full FIFO both occur, and `count` is unchanged.

## Configuration
- `DBUF_CLEAR_EN` defined: the clear engine and starvation guard are compiled in, as described above.
- `DBUF_CLEAR_EN` undefined: there is no FSM or counters.
  - `clr_req` and `clr_color` are ignored.
  - `clr_busy` and `clr_done` are tied to 0.
  - The scheduler reduces to FIFO plus output register.

## Test plan
- **Single pixel:** reset, `mem_ready`=1, one `pix_we` with addr 0x0010 / data 0x00FF8040 at edge N → `mem_we`=1 with exactly those values for the cycle after N+1, then 0.
- **Backpressure/overflow:** `mem_ready`=0, 6 consecutive pixel writes (`FIFO_DEPTH`=4) → output holds word 0. `pix_full` rises after the 5th push. The 6th write is dropped and `pix_ovf`=1. Releasing `mem_ready` drains words 1..4 in order.
- **Clear alone:** `SCREEN_WORDS`=16, `clr_color`=0x00202020, `clr_req` pulse → 16 writes at addresses 0..15, then `clr_done` pulses once and `clr_busy`=0.
- **Starvation guard:** `STARVE_MAX`=2, clear active, continuous pixel writes → the grant pattern on `mem_we` is pixel, pixel, clear, repeating. The clear still completes.
- **Reset mid-clear:** assert `rst` after 5 clear words → all outputs 0 immediately, and no `clr_done`. A new `clr_req` restarts at address 0.
- **Macro off:** build without `DBUF_CLEAR_EN`, pulse `clr_req` → no clear writes, `clr_busy`/`clr_done` stay 0, and the pixel path is unchanged.
